// File: rtl/wb_bus_arbiter_n.sv
// N-master Wishbone arbiter. A winner is registered while idle and then owns
// the single downstream port for its whole cyc transaction, bursts included.
// The next grant always comes after one idle cycle.
// ARB_MODE selects round-robin (0) or fixed priority with index 0 highest (1).
// Optional watchdog: define WB_ARB_TIMEOUT_EN. It aborts a transfer that
// waits TIMEOUT_CYC cycles for an ack and sets a sticky err_o flag.
module wb_bus_arbiter_n #(
  parameter int N_MASTERS   = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int BLW         = 10,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_MASTERS-1:0]        m_cyc_i,
  input  logic [N_MASTERS-1:0]        m_stb_i,
  input  logic [N_MASTERS-1:0]        m_we_i,
  input  logic [N_MASTERS*AW-1:0]     m_adr_i,
  input  logic [N_MASTERS*DW-1:0]     m_dat_i,
  input  logic [N_MASTERS*DW/8-1:0]   m_sel_i,
  input  logic [N_MASTERS*BLW-1:0]    m_bl_i,
  input  logic [N_MASTERS-1:0]        m_bry_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [N_MASTERS-1:0]        m_ack_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [BLW-1:0]              s_bl_o,
  output logic                        s_bry_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  output logic [N_MASTERS-1:0]        grant_o,
  output logic                        err_o
);

  localparam int SW = DW / 8;
  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [N_MASTERS-1:0]  grant, grant_nxt;
  logic [PW-1:0]         owner, owner_nxt;
  logic [PW-1:0]         rr_ptr, rr_ptr_nxt;
  logic [N_MASTERS-1:0]  req;
  logic                  found;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         scan_idx;
  logic                  busy;
  logic                  tmo_fire;
  logic [BLW-1:0]        beat_cnt;

  assign busy    = (state == BUSY);
  assign grant_o = grant;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYC + 1);

  logic [WCW-1:0]        wait_cnt;
  logic [N_MASTERS-1:0]  blocked;
  logic                  err;

  assign tmo_fire = busy && (wait_cnt == WCW'(TIMEOUT_CYC));
  // A master whose transfer timed out may not win again until it drops cyc.
  assign req      = m_cyc_i & ~blocked;
  assign err_o    = err;

  // Watchdog: count stalled strobe cycles, abort on limit, remember offender.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
      blocked  <= '0;
      err      <= 1'b0;
    end else begin
      blocked <= (blocked | (tmo_fire ? grant : '0)) & m_cyc_i;
      if (tmo_fire) err <= 1'b1;
      if (!busy || s_ack_i)
        wait_cnt <= '0;
      else if (s_stb_o && !tmo_fire)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_fire           = 1'b0;
  assign req                = m_cyc_i;
  assign err_o              = 1'b0;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

  // Winner search: from rr_ptr with wrap (round-robin) or from index 0 (fixed).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (ARB_MODE == 1) scan_idx = PW'(k);
      else               scan_idx = PW'((int'(rr_ptr) + k) % N_MASTERS);
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Next-state logic: grant from IDLE, release on owner cyc drop or timeout.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          grant_nxt = N_MASTERS'(1) << win_idx;
          owner_nxt = win_idx;
          if (ARB_MODE == 0)
            rr_ptr_nxt = (win_idx == PW'(N_MASTERS - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      BUSY: begin
        if (!m_cyc_i[owner] || tmo_fire) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so all flops update from the same pre-edge values.
      state  <= state_nxt;
      grant  <= grant_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Downstream mux and ack/data return, all driven from the registered owner.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_bl_o  = '0;
    s_bry_o = 1'b0;
    m_ack_o = '0;
    m_dat_o = '0;
    if (busy) begin
      s_cyc_o = m_cyc_i[owner];
      s_stb_o = m_stb_i[owner];
      s_we_o  = m_we_i[owner];
      s_adr_o = m_adr_i[owner*AW +: AW];
      s_dat_o = m_dat_i[owner*DW +: DW];
      s_sel_o = m_sel_i[owner*SW +: SW];
      s_bl_o  = m_bl_i[owner*BLW +: BLW];
      s_bry_o = m_bry_i[owner];
      m_ack_o = grant & {N_MASTERS{s_ack_i | tmo_fire}};
      m_dat_o = tmo_fire ? DW'(32'hDEAD_BEEF) : s_dat_i;
    end
  end

  // Beat counter: cleared on each grant, counts acked strobes; debug only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      beat_cnt <= '0;
    else if (!busy && found)
      beat_cnt <= '0;
    else if (busy && s_ack_i && s_stb_o)
      beat_cnt <= beat_cnt + 1'b1;
  end

  // beat_cnt has no port; keep it referenced so it is not flagged as dead.
  logic unused_beat_cnt;
  assign unused_beat_cnt = ^beat_cnt;

endmodule
